// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared constants and types for the inter-stage pipeline register.
//   - default widths (data/PC, register number, T_new) and the reset PC
//   - bubble values for the control bundle and the exception code
//   - the per-edge action enum (reset > flush > hold > load)
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_A3_W   = 5;
  localparam int PIPE_TNEW_W = 2;
  localparam int PIPE_EXC_W  = 5;

  localparam logic [31:0] PIPE_RESET_PC = 32'h0000_3000;

  // A bubble carries an all-zero control bundle and no exception.
  localparam logic                  CTRL_BUBBLE_BIT = 1'b0;
  localparam logic [PIPE_EXC_W-1:0] EXC_BUBBLE      = '0;

  typedef enum logic [1:0] {
    ACT_RESET = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_HOLD  = 2'd2,
    ACT_LOAD  = 2'd3
  } stage_act_e;

  // Resolve the per-edge action from the control inputs in priority order.
  function automatic stage_act_e pick_act(input logic reset, input logic flush,
                                          input logic stall);
    if (reset)      return ACT_RESET;
    else if (flush) return ACT_FLUSH;
    else if (stall) return ACT_HOLD;
    else            return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_tnew_sat_dec.sv
// tnew_sat_dec: saturating decrement of the hazard T_new countdown.
// Ports:
//   val_i  in  W : current T_new value
//   en_i   in  1 : decrement enable
//   dec_o  out W : val_i - 1 when enabled and nonzero, else val_i (0 never wraps)
module tnew_sat_dec #(
  parameter int W = 2
) (
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] dec_o
);

  always_comb begin
    dec_o = val_i;
    if (en_i && (val_i != '0)) dec_o = val_i - W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage register for the five-stage MIPS core
// (D/E, E/M, M/W). Carries PC, control bundle, destination register, data
// lanes and the T_new countdown, with stall (hold), flush (bubble), a valid
// bit and $0-write normalisation. All outputs come straight from registers.
//
// Optional feature macro: PIPE_STAGE_EXC_EN adds exc_in/exc_out (ExcCode) and
// bd_in/bd_out (branch-delay flag).
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   stall, flush          hold current contents / load a bubble (flush wins)
//   valid_in, PC_in, T_new_in, RegWrite_in, ctrl_in, A3_in, data_in
//                         upstream stage fields (lane k = data_in[k*DATA_W +: DATA_W])
//   valid_out, PC_out, T_new_out, RegWrite_out, ctrl_out, A3_out, data_out
//                         registered counterparts
//   T_new_zero            decode of T_new_out == 0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = PIPE_DATA_W,
  parameter int                DATA_N   = 2,
  parameter int                CTRL_W   = 8,
  parameter int                TNEW_W   = PIPE_TNEW_W,
  parameter int                A3_W     = PIPE_A3_W,
  parameter logic [DATA_W-1:0] RESET_PC = PIPE_RESET_PC,
  parameter int                TNEW_DEC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        PC_in,
  input  logic [TNEW_W-1:0]        T_new_in,
  input  logic                     RegWrite_in,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic [A3_W-1:0]          A3_in,
  input  logic [DATA_N*DATA_W-1:0] data_in,
`ifdef PIPE_STAGE_EXC_EN
  input  logic [PIPE_EXC_W-1:0]    exc_in,
  input  logic                     bd_in,
  output logic [PIPE_EXC_W-1:0]    exc_out,
  output logic                     bd_out,
`endif
  output logic                     valid_out,
  output logic [DATA_W-1:0]        PC_out,
  output logic [TNEW_W-1:0]        T_new_out,
  output logic                     RegWrite_out,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic [A3_W-1:0]          A3_out,
  output logic [DATA_N*DATA_W-1:0] data_out,
  output logic                     T_new_zero
);

  logic                     valid_q, valid_d;
  logic [DATA_W-1:0]        pc_q, pc_d;
  logic [TNEW_W-1:0]        tnew_q, tnew_d;
  logic                     rw_q, rw_d;
  logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
  logic [A3_W-1:0]          a3_q, a3_d;
  logic [DATA_N*DATA_W-1:0] data_q, data_d;
`ifdef PIPE_STAGE_EXC_EN
  logic [PIPE_EXC_W-1:0]    exc_q, exc_d;
  logic                     bd_q, bd_d;
`endif

  stage_act_e        act;
  logic [TNEW_W-1:0] tnew_load;
  logic              a3_ok;
  logic              rw_ok;

  tnew_sat_dec #(.W(TNEW_W)) u_tnew_dec (
    .val_i (T_new_in),
    .en_i  (TNEW_DEC != 0),
    .dec_o (tnew_load)
  );

  // A write to $0 or from a non-instruction is dropped entirely so that
  // forwarding comparators downstream can never match register 0.
  assign a3_ok = valid_in && (A3_in != '0);
`ifdef PIPE_STAGE_EXC_EN
  assign rw_ok = a3_ok && (exc_in == EXC_BUBBLE);
`else
  assign rw_ok = a3_ok;
`endif

  assign act = pick_act(reset, flush, stall);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    tnew_d  = tnew_q;
    rw_d    = rw_q;
    ctrl_d  = ctrl_q;
    a3_d    = a3_q;
    data_d  = data_q;
`ifdef PIPE_STAGE_EXC_EN
    exc_d   = exc_q;
    bd_d    = bd_q;
`endif
    unique case (act)
      ACT_FLUSH: begin
        // Bubble keeps its PC (and BD) so an exception on it reports a correct EPC.
        valid_d = 1'b0;
        pc_d    = PC_in;
        tnew_d  = '0;
        rw_d    = 1'b0;
        ctrl_d  = {CTRL_W{CTRL_BUBBLE_BIT}};
        a3_d    = '0;
        data_d  = '0;
`ifdef PIPE_STAGE_EXC_EN
        exc_d   = EXC_BUBBLE;
        bd_d    = bd_in;
`endif
      end
      ACT_LOAD: begin
        valid_d = valid_in;
        pc_d    = PC_in;
        tnew_d  = tnew_load;
        rw_d    = RegWrite_in && rw_ok;
        ctrl_d  = ctrl_in;
        a3_d    = a3_ok ? A3_in : '0;
        data_d  = data_in;
`ifdef PIPE_STAGE_EXC_EN
        exc_d   = exc_in;
        bd_d    = bd_in;
`endif
      end
      default: ;  // ACT_HOLD holds; ACT_RESET is applied in the register block
    endcase
  end

  // ---- stage register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      tnew_q  <= '0;
      rw_q    <= 1'b0;
      ctrl_q  <= '0;
      a3_q    <= '0;
      data_q  <= '0;
`ifdef PIPE_STAGE_EXC_EN
      exc_q   <= '0;
      bd_q    <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      tnew_q  <= tnew_d;
      rw_q    <= rw_d;
      ctrl_q  <= ctrl_d;
      a3_q    <= a3_d;
      data_q  <= data_d;
`ifdef PIPE_STAGE_EXC_EN
      exc_q   <= exc_d;
      bd_q    <= bd_d;
`endif
    end
  end

  assign valid_out    = valid_q;
  assign PC_out       = pc_q;
  assign T_new_out    = tnew_q;
  assign RegWrite_out = rw_q;
  assign ctrl_out     = ctrl_q;
  assign A3_out       = a3_q;
  assign data_out     = data_q;
  assign T_new_zero   = (tnew_q == '0);
`ifdef PIPE_STAGE_EXC_EN
  assign exc_out      = exc_q;
  assign bd_out       = bd_q;
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the fixed-function D/E, E/M and M/W registers with one block. It carries PC, a generic control bundle, destination register number, data lanes and the hazard T_new countdown. It adds stall (hold), flush (bubble insertion), a valid bit and `$0`-write normalisation. It sits between any two adjacent stages and is driven by the hazard unit.

## Interface
Parameters:
- `DATA_W`, 32: width of PC and of each data lane.
- `DATA_N`, 2: number of data lanes, for example ALU result and DM read data.
- `CTRL_W`, 8: width of the opaque control bundle, excluding RegWrite.
- `TNEW_W`, 2: width of the T_new field.
- `A3_W`, 5: register-number width.
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `TNEW_DEC`, 1: 1 = decrement T_new on each advance (saturating at 0); 0 = pass through unchanged.

Ports (all outputs registered):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold the current contents.
- `flush` in 1: load a bubble.
- `valid_in` in 1: upstream instruction is real.
- `PC_in` in DATA_W: instruction PC.
- `T_new_in` in TNEW_W: cycles until the result is available.
- `RegWrite_in` in 1: GRF write enable.
- `ctrl_in` in CTRL_W: control bundle (MemtoReg, etc.).
- `A3_in` in A3_W: destination register.
- `data_in` in DATA_N*DATA_W: lanes; lane k is bits [k*DATA_W +: DATA_W].
- `valid_out`, `PC_out`, `T_new_out`, `RegWrite_out`, `ctrl_out`, `A3_out`, `data_out`: registered counterparts of the above.
- `T_new_zero` out 1: `T_new_out == 0`, decoded from the register.

## Operation
- Per rising edge, priority reset > flush > stall > load.
- **Reset:**
  - `PC_out` = RESET_PC.
  - All other outputs 0; `T_new_zero` = 1.
- **Flush (bubble):**
  - `valid_out`, `RegWrite_out`, `ctrl_out`, `A3_out`, `data_out` and `T_new_out` = 0.
  - `PC_out` = PC_in, kept for EPC and debug.
  - Flush overrides a simultaneous stall.
- **Stall:** all registers hold, including T_new. No decrement while held.
- **Load:**
  - All fields are captured from the inputs.
  - T_new_out = (TNEW_DEC && T_new_in != 0) ? T_new_in - 1 : T_new_in. Decrement is unsigned and never wraps: 0 stays 0.
- **Normalisation on load:**
  - If `A3_in == 0` or `valid_in == 0`, then RegWrite_out = 0 and A3_out = 0.
  - This guarantees forwarding never matches `$0`.
  - `ctrl_out` and `data_out` are still captured.
- `T_new_zero` is purely a decode of the `T_new_out` register and is never held separately.

## Timing
- Latency: 1 cycle from input to output on load.
- Stall: outputs are stable for every cycle `stall` is high. The first edge with `stall` low loads the current inputs.
- Flush: the bubble is visible on the cycle after the flush edge.
- Reset mid-stall or mid-flush: reset wins on that edge, and the next edge behaves per the inputs.
- Inputs are sampled only at the edge; there are no combinational paths from inputs to outputs.

## Configuration
- `PIPE_STAGE_EXC_EN` defined adds the following ports:
  - `exc_in`/`exc_out` (5 bits, ExcCode) and `bd_in`/`bd_out` (1 bit, branch-delay flag).
  - These follow the load and stall rules.
  - On flush, `exc_out` = 0 and `bd_out` = `bd_in`, preserving BD for the bubble's EPC.
  - On load, a nonzero `exc_in` forces RegWrite_out = 0.
- Undefined: the ports are absent and the behaviour is otherwise identical.

## Structure
- Package `pipe_pkg`:
  - Width constants (DATA_W, A3_W, TNEW_W defaults) and RESET_PC.
  - Bubble constants for control and ExcCode.
  - Enum of the priority actions (RESET, FLUSH, HOLD, LOAD).
- Sub-module `tnew_sat_dec`: saturating decrement, TNEW_W wide, with an enable. One instance in the block.

## Test plan
- Reset high for one edge with all inputs at 1s → PC_out = 0x00003000, all other outputs 0, `T_new_zero` = 1.
- Load PC_in = 0x3004, T_new_in = 2, A3_in = 8, RegWrite_in = 1, valid_in = 1 → next cycle T_new_out = 1, RegWrite_out = 1, A3_out = 8, valid_out = 1. With T_new_in = 0 → T_new_out = 0 (no wrap).
- Stall for 3 cycles after loading T_new = 2 while the inputs change → T_new_out stays 1 and all outputs are unchanged. Releasing stall loads the new inputs.
- Flush and stall together, with PC_in = 0x3010 and RegWrite_in = 1 → valid_out = 0, RegWrite_out = 0, A3_out = 0, PC_out = 0x3010.
- A3_in = 0 with RegWrite_in = 1 and valid_in = 1 → RegWrite_out = 0, A3_out = 0, and data lanes captured.
- With `PIPE_STAGE_EXC_EN` defined, exc_in = 12 and RegWrite_in = 1 → exc_out = 12 and RegWrite_out = 0. A following flush with bd_in = 1 → exc_out = 0 and bd_out = 1.
